// File: rtl/handshake_issue_sequencer.sv
// Upstream sequencer for the clk2-domain req/ack talker: queues commands, issues start pulses,
// counts completions and watches for stalled or malformed handshakes. Optional SEQ_STATS_EN adds lat_max.
module handshake_issue_sequencer #(
    parameter int unsigned MAX_PENDING = 15,
    parameter int unsigned PEND_W      = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1023,
    parameter int unsigned TO_W        = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              err_clear,
    input  logic              ready,
    input  logic              rcv,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              timeout_err,
    output logic              proto_err,
    output logic [TO_W-1:0]   lat_max
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [PEND_W-1:0] MAX_P   = PEND_W'(MAX_PENDING);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]    xfer_count_q, xfer_count_d;
    logic [TO_W-1:0]     wd_q, wd_d;
    logic                rcv_seen_q, rcv_seen_d;
    logic                timeout_err_q, timeout_err_d;
    logic                proto_err_q, proto_err_d;
    logic                done_q, done_d;
    logic                start_q, busy_q, cmd_ready_q, cmd_ready_d;
    logic                accept_s, issue_s;
    logic [TO_W-1:0]     wd_inc_s;

    assign accept_s = cmd_valid & cmd_ready_q;
    assign wd_inc_s = wd_q + TO_W'(1);

    // Next-state, queue bookkeeping, watchdog and error flags.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        xfer_count_d  = xfer_count_q;
        wd_d          = wd_q;
        rcv_seen_d    = rcv_seen_q;
        timeout_err_d = timeout_err_q;
        proto_err_d   = proto_err_q;
        done_d        = 1'b0;
        issue_s       = 1'b0;

        // Clear first so that an error detected in the same cycle still sticks.
        if (err_clear) begin
            timeout_err_d = 1'b0;
            proto_err_d   = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
            proto_err_d   = proto_err_q;
        end

        case (state_q)
            ST_IDLE: begin
                wd_d = {TO_W{1'b0}};
                if ((pending_q != {PEND_W{1'b0}}) && ready) begin
                    state_d    = ST_ISSUE;
                    issue_s    = 1'b1;
                    rcv_seen_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                wd_d = wd_inc_s;
                if (wd_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_ERROR;
                end else if (!ready) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                wd_d = wd_inc_s;
                if (rcv) begin
                    rcv_seen_d = 1'b1;
                end else begin
                    rcv_seen_d = rcv_seen_q;
                end
                if (wd_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_ERROR;
                end else if (ready && !rcv) begin
                    if (rcv_seen_q) begin
                        state_d      = ST_IDLE;
                        done_d       = 1'b1;
                        xfer_count_d = xfer_count_q + CNT_W'(1);
                    end else begin
                        proto_err_d = 1'b1;
                        state_d     = ST_ERROR;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    state_d = ST_IDLE;
                    wd_d    = {TO_W{1'b0}};
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case ({accept_s, issue_s})
            2'b10:   pending_d = pending_q + PEND_W'(1);
            2'b01:   pending_d = pending_q - PEND_W'(1);
            default: pending_d = pending_q;
        endcase

        cmd_ready_d = (pending_d < MAX_P);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pending_q     <= {PEND_W{1'b0}};
            xfer_count_q  <= {CNT_W{1'b0}};
            wd_q          <= {TO_W{1'b0}};
            rcv_seen_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            xfer_count_q  <= xfer_count_d;
            wd_q          <= wd_d;
            rcv_seen_q    <= rcv_seen_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
            done_q        <= done_d;
            start_q       <= (state_d == ST_ISSUE);
            busy_q        <= (state_d == ST_ISSUE) || (state_d == ST_BUSY);
            cmd_ready_q   <= cmd_ready_d;
        end
    end

`ifdef SEQ_STATS_EN
    logic [TO_W-1:0] lat_max_q;

    // Peak issue-to-completion latency, sampled together with done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_max_q <= {TO_W{1'b0}};
        end else if (done_d && (wd_inc_s > lat_max_q)) begin
            lat_max_q <= wd_inc_s;
        end else begin
            lat_max_q <= lat_max_q;
        end
    end

    assign lat_max = lat_max_q;
`else
    assign lat_max = {TO_W{1'b0}};
`endif

    assign cmd_ready   = cmd_ready_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pending     = pending_q;
    assign xfer_count  = xfer_count_q;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;

endmodule
